single_result_collector: RTL and testbench

Downstream stage of the single-PE convolution path. Captures the four 8-bit results the single-PE engine emits (one per `en_result` pulse) for a 4x4 input convolved with a 3x3 kernel, stores them as the 2x2 output matrix, and streams them out in raster order over a valid/ready port. It also flags protocol violations from the PE stage.

---
 rtl/single_result_collector.sv | 224 ++++++++++++++++++++++
 tb/tb_single_result_collector.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_result_collector.sv
// ---------------------------------------------------------------------------
// single_result_collector
//
// Collects the four 8-bit results produced by the single-PE convolution
// engine (4x4 input, 3x3 kernel -> 2x2 output), holds them as the output
// matrix and streams them out in raster order over a valid/ready port.
// Protocol violations from the PE stage raise a sticky error flag.
//
// State   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | not armed; waiting for en_single
// COLLECT | capturing acc_in on each en_result strobe into c_* by wr_idx
// STREAM  | presenting c_* by rd_idx on out_data, advancing on handshake
// DONE    | all four handshakes complete; holding until en_single drops
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous active-low reset
//   en_single     level arm; low returns the block to IDLE
//   en_result     one-cycle capture strobe, acc_in valid with it
//   acc_in[7:0]   result from the PE stage
//   pe_done       PE completion pulse (early arrival is an error)
//   c_1_1..c_2_2  stored 2x2 result matrix
//   result_valid  all four results of the current run are held
//   out_data[7:0] streamed element
//   out_valid     stream valid
//   out_ready     stream ready from consumer
//   out_last      marks the fourth streamed element
//   collect_done  set after the final handshake, until en_single drops
//   err           sticky protocol-error flag, cleared on arm or reset
// ---------------------------------------------------------------------------
module single_result_collector (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_single,
    input  logic       en_result,
    input  logic [7:0] acc_in,
    input  logic       pe_done,
    output logic [7:0] c_1_1,
    output logic [7:0] c_1_2,
    output logic [7:0] c_2_1,
    output logic [7:0] c_2_2,
    output logic       result_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       collect_done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        STREAM  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] wr_idx_q, wr_idx_d;
    logic [1:0] rd_idx_q, rd_idx_d;
    logic [1:0] rd_idx_inc;
    logic [7:0] c11_q, c11_d, c12_q, c12_d, c21_q, c21_d, c22_q, c22_d;
    logic       result_valid_q, result_valid_d;
    logic       collect_done_q, collect_done_d;
    logic       err_q, err_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;
    logic [7:0] out_data_q, out_data_d;
    logic [7:0] next_elem;
    logic       abort;

    // Element that follows the one currently on out_data; loaded into the
    // output register on a handshake so out_data stays fully registered.
    always_comb begin
        rd_idx_inc = rd_idx_q + 2'd1;
        case (rd_idx_inc)
            2'd0:    next_elem = c11_q;
            2'd1:    next_elem = c12_q;
            2'd2:    next_elem = c21_q;
            default: next_elem = c22_q;
        endcase
    end

    assign abort = (state_q != IDLE) && !en_single;

    always_comb begin
        state_d        = state_q;
        wr_idx_d       = wr_idx_q;
        rd_idx_d       = rd_idx_q;
        c11_d          = c11_q;
        c12_d          = c12_q;
        c21_d          = c21_q;
        c22_d          = c22_q;
        result_valid_d = result_valid_q;
        collect_done_d = collect_done_q;
        err_d          = err_q;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        out_data_d     = out_data_q;

        case (state_q)
            IDLE: begin
                if (en_result) begin
                    err_d = 1'b1;
                end
                if (en_single) begin
                    state_d        = COLLECT;
                    wr_idx_d       = 2'd0;
                    rd_idx_d       = 2'd0;
                    result_valid_d = 1'b0;
                    // A strobe in the arming cycle still counts as an error.
                    err_d          = en_result;
                end
            end
            COLLECT: begin
                if (en_single) begin
                    // pe_done is legal only together with or after the 4th capture
                    if (pe_done && !(en_result && (wr_idx_q == 2'd3))) begin
                        err_d = 1'b1;
                    end
                    if (en_result) begin
                        case (wr_idx_q)
                            2'd0:    c11_d = acc_in;
                            2'd1:    c12_d = acc_in;
                            2'd2:    c21_d = acc_in;
                            default: c22_d = acc_in;
                        endcase
                        wr_idx_d = wr_idx_q + 2'd1;
                        if (wr_idx_q == 2'd3) begin
                            state_d        = STREAM;
                            result_valid_d = 1'b1;
                            out_valid_d    = 1'b1;
                            out_last_d     = 1'b0;
                            out_data_d     = c11_q;
                            rd_idx_d       = 2'd0;
                        end
                    end
                end
            end
            STREAM: begin
                if (en_result) begin
                    err_d = 1'b1;
                end
                if (out_ready) begin
                    if (rd_idx_q == 2'd3) begin
                        state_d        = DONE;
                        out_valid_d    = 1'b0;
                        out_last_d     = 1'b0;
                        out_data_d     = 8'd0;
                        collect_done_d = 1'b1;
                        rd_idx_d       = rd_idx_inc;
                    end else begin
                        rd_idx_d   = rd_idx_inc;
                        out_data_d = next_elem;
                        out_last_d = (rd_idx_inc == 2'd3);
                    end
                end
            end
            DONE: begin
                if (en_result) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Dropping the arm abandons the run but keeps the matrix and err.
        if (abort) begin
            state_d        = IDLE;
            out_valid_d    = 1'b0;
            out_last_d     = 1'b0;
            out_data_d     = 8'd0;
            collect_done_d = 1'b0;
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            wr_idx_q       <= 2'd0;
            rd_idx_q       <= 2'd0;
            c11_q          <= 8'd0;
            c12_q          <= 8'd0;
            c21_q          <= 8'd0;
            c22_q          <= 8'd0;
            result_valid_q <= 1'b0;
            collect_done_q <= 1'b0;
            err_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_data_q     <= 8'd0;
        end else begin
            state_q        <= state_d;
            wr_idx_q       <= wr_idx_d;
            rd_idx_q       <= rd_idx_d;
            c11_q          <= c11_d;
            c12_q          <= c12_d;
            c21_q          <= c21_d;
            c22_q          <= c22_d;
            result_valid_q <= result_valid_d;
            collect_done_q <= collect_done_d;
            err_q          <= err_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            out_data_q     <= out_data_d;
        end
    end

    assign c_1_1        = c11_q;
    assign c_1_2        = c12_q;
    assign c_2_1        = c21_q;
    assign c_2_2        = c22_q;
    assign result_valid = result_valid_q;
    assign collect_done = collect_done_q;
    assign err          = err_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign out_data     = out_data_q;

endmodule

// File: tb/tb_single_result_collector.sv
// ---------------------------------------------------------------------------
// tb_single_result_collector
//
// Directed bench for single_result_collector. Inputs change 1 time unit
// after a rising edge and outputs are checked at that same point, i.e. the
// values shown are those registered at the preceding edge.
// ---------------------------------------------------------------------------
module tb_single_result_collector;

    logic       clk;
    logic       reset;
    logic       en_single;
    logic       en_result;
    logic [7:0] acc_in;
    logic       pe_done;
    logic [7:0] c_1_1, c_1_2, c_2_1, c_2_2;
    logic       result_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       collect_done;
    logic       err;

    int total = 0;
    int bad   = 0;

    single_result_collector dut (
        .clk          (clk),
        .reset        (reset),
        .en_single    (en_single),
        .en_result    (en_result),
        .acc_in       (acc_in),
        .pe_done      (pe_done),
        .c_1_1        (c_1_1),
        .c_1_2        (c_1_2),
        .c_2_1        (c_2_1),
        .c_2_2        (c_2_2),
        .result_valid (result_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .collect_done (collect_done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [7:0] v);
        en_result = 1'b1;
        acc_in    = v;
        tick();
        en_result = 1'b0;
        acc_in    = 8'h00;
    endtask

    task automatic arm();
        en_single = 1'b0;
        tick();
        en_single = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total++;
        if ({c_1_1, c_1_2, c_2_1, c_2_2} !== 32'h0) begin
            bad++;
            $display("FAIL reset_matrix: got %h want 00000000", {c_1_1, c_1_2, c_2_1, c_2_2});
        end
        total++;
        if ({out_data, out_valid, out_last, result_valid, collect_done, err} !== 13'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0000",
                     {out_data, out_valid, out_last, result_valid, collect_done, err});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp_v [4];
        exp_v[0] = 8'h11; exp_v[1] = 8'h22; exp_v[2] = 8'h33; exp_v[3] = 8'h44;
        en_single = 1'b1;
        tick();
        total++;
        if ({out_valid, result_valid, err} !== 3'b000) begin
            bad++;
            $display("FAIL basic_armed: got %b want 000", {out_valid, result_valid, err});
        end
        capture(8'h11);
        total++;
        if (c_1_1 !== 8'h11) begin
            bad++;
            $display("FAIL basic_first_capture: got %h want 11", c_1_1);
        end
        capture(8'h22);
        capture(8'h33);
        pe_done = 1'b1;   // same cycle as the 4th capture: legal
        capture(8'h44);
        pe_done = 1'b0;
        total++;
        if ({c_1_1, c_1_2, c_2_1, c_2_2} !== 32'h11223344) begin
            bad++;
            $display("FAIL basic_matrix: got %h want 11223344", {c_1_1, c_1_2, c_2_1, c_2_2});
        end
        total++;
        if ({result_valid, out_valid, out_last, err, out_data} !== {4'b1100, 8'h11}) begin
            bad++;
            $display("FAIL basic_stream_start: got %h want c11",
                     {result_valid, out_valid, out_last, err, out_data});
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({out_valid, out_last, out_data} !== {1'b1, (k == 3), exp_v[k]}) begin
                bad++;
                $display("FAIL basic_stream[%0d]: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                         k, out_valid, out_last, out_data, (k == 3), exp_v[k]);
            end
            tick();
        end
        out_ready = 1'b0;
        total++;
        if ({collect_done, out_valid, result_valid, err} !== 4'b1010) begin
            bad++;
            $display("FAIL basic_done: got %b want 1010",
                     {collect_done, out_valid, result_valid, err});
        end
        en_single = 1'b0;
        tick();
        total++;
        if ({collect_done, result_valid, out_valid, c_1_1, c_1_2, c_2_1, c_2_2}
                !== {3'b000, 32'h11223344}) begin
            bad++;
            $display("FAIL basic_disarm: got %h want 011223344",
                     {collect_done, result_valid, out_valid, c_1_1, c_1_2, c_2_1, c_2_2});
        end
    endtask

    task automatic test_idle_strobe();
        capture(8'h99);
        total++;
        if ({err, c_1_1, c_1_2, c_2_1, c_2_2} !== {1'b1, 32'h11223344}) begin
            bad++;
            $display("FAIL idle_strobe: got %h want 111223344",
                     {err, c_1_1, c_1_2, c_2_1, c_2_2});
        end
        en_single = 1'b1;
        tick();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL idle_strobe_rearm_clear: got %b want 0", err);
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_v [4];
        int idx;
        exp_v[0] = 8'h11; exp_v[1] = 8'h22; exp_v[2] = 8'h33; exp_v[3] = 8'h44;
        arm();
        capture(8'h11);
        capture(8'h22);
        capture(8'h33);
        capture(8'h44);
        idx = 0;
        for (int cyc = 0; cyc < 24 && idx < 4; cyc++) begin
            out_ready = (cyc % 3 == 0);
            total++;
            if ({out_valid, out_last, out_data} !== {1'b1, (idx == 3), exp_v[idx]}) begin
                bad++;
                $display("FAIL stall_stream[c%0d]: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                         cyc, out_valid, out_last, out_data, (idx == 3), exp_v[idx]);
            end
            tick();
            if (out_ready) idx++;
        end
        out_ready = 1'b0;
        total++;
        if ({(idx == 4), collect_done, out_valid} !== 3'b110) begin
            bad++;
            $display("FAIL stall_done: got idx=%0d done=%b v=%b want idx=4 done=1 v=0",
                     idx, collect_done, out_valid);
        end
    endtask

    task automatic test_pe_done_early();
        logic [7:0] exp_v [4];
        exp_v[0] = 8'hA1; exp_v[1] = 8'hA2; exp_v[2] = 8'hA3; exp_v[3] = 8'hA4;
        arm();
        capture(8'hA1);
        capture(8'hA2);
        pe_done = 1'b1;
        tick();
        pe_done = 1'b0;
        total++;
        if ({err, result_valid, out_valid} !== 3'b100) begin
            bad++;
            $display("FAIL early_pe_done: got %b want 100", {err, result_valid, out_valid});
        end
        capture(8'hA3);
        capture(8'hA4);
        total++;
        if ({c_1_1, c_1_2, c_2_1, c_2_2, result_valid, out_valid, out_data}
                !== {32'hA1A2A3A4, 2'b11, 8'hA1}) begin
            bad++;
            $display("FAIL early_pe_done_matrix: got %h want a1a2a3a43a1",
                     {c_1_1, c_1_2, c_2_1, c_2_2, result_valid, out_valid, out_data});
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({out_valid, out_last, out_data} !== {1'b1, (k == 3), exp_v[k]}) begin
                bad++;
                $display("FAIL early_pe_done_stream[%0d]: got v=%b l=%b d=%h want d=%h",
                         k, out_valid, out_last, out_data, exp_v[k]);
            end
            tick();
        end
        out_ready = 1'b0;
        total++;
        if ({collect_done, err} !== 2'b11) begin
            bad++;
            $display("FAIL early_pe_done_end: got %b want 11", {collect_done, err});
        end
    endtask

    task automatic test_extra_result();
        logic [7:0] exp_v [4];
        exp_v[0] = 8'h11; exp_v[1] = 8'h22; exp_v[2] = 8'h33; exp_v[3] = 8'h44;
        arm();
        capture(8'h11);
        capture(8'h22);
        capture(8'h33);
        capture(8'h44);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL extra_pre_err: got %b want 0", err);
        end
        capture(8'hFF);
        total++;
        if ({err, c_2_2, out_valid, out_last, out_data} !== {1'b1, 8'h44, 2'b10, 8'h11}) begin
            bad++;
            $display("FAIL extra_result: got %h want 1444211",
                     {err, c_2_2, out_valid, out_last, out_data});
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({out_valid, out_last, out_data} !== {1'b1, (k == 3), exp_v[k]}) begin
                bad++;
                $display("FAIL extra_stream[%0d]: got v=%b l=%b d=%h want d=%h",
                         k, out_valid, out_last, out_data, exp_v[k]);
            end
            tick();
        end
        out_ready = 1'b0;
        capture(8'hEE);
        total++;
        if ({collect_done, out_valid, c_1_1, c_1_2, c_2_1, c_2_2} !== {2'b10, 32'h11223344}) begin
            bad++;
            $display("FAIL extra_in_done: got %h want 211223344",
                     {collect_done, out_valid, c_1_1, c_1_2, c_2_1, c_2_2});
        end
    endtask

    task automatic test_abort();
        logic [7:0] exp_v [4];
        exp_v[0] = 8'h01; exp_v[1] = 8'h02; exp_v[2] = 8'h03; exp_v[3] = 8'h04;
        arm();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL abort_arm_clear: got %b want 0", err);
        end
        capture(8'h11);
        capture(8'h22);
        capture(8'h33);
        capture(8'h44);
        en_result = 1'b1;
        acc_in    = 8'hFF;
        out_ready = 1'b1;
        tick();
        en_result = 1'b0;
        acc_in    = 8'h00;
        total++;
        if ({err, out_data} !== {1'b1, 8'h22}) begin
            bad++;
            $display("FAIL abort_first_hs: got %h want 122", {err, out_data});
        end
        tick();
        total++;
        if (out_data !== 8'h33) begin
            bad++;
            $display("FAIL abort_second_hs: got %h want 33", out_data);
        end
        en_single = 1'b0;
        out_ready = 1'b0;
        tick();
        total++;
        if ({out_valid, result_valid, collect_done, out_last, err, c_1_1, c_1_2, c_2_1, c_2_2}
                !== {5'b00001, 32'h11223344}) begin
            bad++;
            $display("FAIL abort_idle: got %h want 111223344",
                     {out_valid, result_valid, collect_done, out_last, err,
                      c_1_1, c_1_2, c_2_1, c_2_2});
        end
        en_single = 1'b1;
        tick();
        total++;
        if ({err, result_valid, out_valid} !== 3'b000) begin
            bad++;
            $display("FAIL abort_rearm: got %b want 000", {err, result_valid, out_valid});
        end
        capture(8'h01);
        capture(8'h02);
        capture(8'h03);
        capture(8'h04);
        total++;
        if ({c_1_1, c_1_2, c_2_1, c_2_2} !== 32'h01020304) begin
            bad++;
            $display("FAIL abort_fresh_matrix: got %h want 01020304",
                     {c_1_1, c_1_2, c_2_1, c_2_2});
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({out_valid, out_last, out_data} !== {1'b1, (k == 3), exp_v[k]}) begin
                bad++;
                $display("FAIL abort_fresh_stream[%0d]: got v=%b l=%b d=%h want d=%h",
                         k, out_valid, out_last, out_data, exp_v[k]);
            end
            tick();
        end
        out_ready = 1'b0;
        total++;
        if ({collect_done, err} !== 2'b10) begin
            bad++;
            $display("FAIL abort_fresh_done: got %b want 10", {collect_done, err});
        end
    endtask

    task automatic test_reset_mid();
        arm();
        capture(8'h55);
        capture(8'h66);
        en_result = 1'b1;
        acc_in    = 8'h77;
        reset     = 1'b0;
        tick();
        total++;
        if ({c_1_1, c_1_2, c_2_1, c_2_2} !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_matrix: got %h want 00000000",
                     {c_1_1, c_1_2, c_2_1, c_2_2});
        end
        total++;
        if ({out_data, out_valid, out_last, result_valid, collect_done, err} !== 13'h0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got %h want 0000",
                     {out_data, out_valid, out_last, result_valid, collect_done, err});
        end
        reset     = 1'b1;
        en_result = 1'b0;
        en_single = 1'b0;
        tick();
        total++;
        if ({c_1_1, out_valid, err} !== 10'h0) begin
            bad++;
            $display("FAIL reset_mid_after: got %h want 000", {c_1_1, out_valid, err});
        end
    endtask

    initial begin
        reset     = 1'b0;
        en_single = 1'b0;
        en_result = 1'b0;
        acc_in    = 8'h00;
        pe_done   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_idle_strobe();
        test_stall();
        test_pe_done_early();
        test_extra_result();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
